nibble_serial_adder: RTL and testbench

- Sequential driver/consumer for the 4-bit ripple adder slice: accepts two wide operands and feeds them one nibble per cycle into an external 4-bit adder (a, b, cin -> sum, cout).
- Chains the slice's carry out back into its next carry in, and assembles the nibble sums into a wide result.
- Sits directly upstream and downstream of the 4-bit adder: drives its inputs and consumes its outputs.
- Valid/ready handshake on both the operand side and the result side.

---
 rtl/nibble_serial_adder.sv | 124 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Serial wide adder: feeds an external 4-bit adder slice one nibble per cycle, chaining its carry.
// Result valid NIBBLES cycles after accept; holds result in DONE until out_ready, no accept outside IDLE.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   op_cin,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     result_q, result_d;
  logic             cout_q, cout_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    cout_d    = cout_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = 4'h0;
    add_b     = 4'h0;
    add_cin   = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d      = op_a;
          b_d      = op_b;
          carry_d  = op_cin;
          idx_d    = '0;
          result_d = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        // Only the active nibble is driven to the slice; its sum lands in the same lane.
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDX_W'(i)) begin
            add_a              = a_q[4*i +: 4];
            add_b              = b_q[4*i +: 4];
            result_d[4*i +: 4] = add_sum;
          end
        end
        add_cin = carry_q;
        carry_d = add_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: behavioural 4-bit slice, arithmetic reference model and result scoreboard.
module tb_nibble_serial_adder;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid, in_ready;
  logic [W-1:0] op_a, op_b;
  logic         op_cin;
  logic [3:0]   add_a, add_b, slice_sum;
  logic         add_cin, slice_cout;
  logic         out_valid, out_ready;
  logic [W-1:0] result;
  logic         cout;

  int           checks = 0;
  int           errors = 0;
  logic [W:0]   sb[$];
  logic [W:0]   mon_exp;

  nibble_serial_adder #(.NIBBLES(NIB)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_cin   (op_cin),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (slice_sum),
    .add_cout (slice_cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .cout     (cout)
  );

  // The external 4-bit adder slice.
  assign {slice_cout, slice_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every completed result handshake is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got 0x%0h, expected no result", {cout, result});
      end else begin
        mon_exp = sb.pop_front();
        chk("result", {15'b0, cout, result}, {15'b0, mon_exp});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input bit hold, output int waited);
    op_a     = a;
    op_b     = b;
    op_cin   = cin;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, expected 1", waited);
    end else begin
      sb.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
      @(posedge clk);
      #1;
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output logic [NIB-1:0] cins);
    cycles = 0;
    cins   = '0;
    while (!out_valid && cycles < 50) begin
      if (cycles < NIB) cins[cycles] = add_cin;
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic simple_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input string name, output logic [NIB-1:0] cins);
    int w, lat;
    issue(a, b, cin, 1'b0, w);
    wait_done(lat, cins);
    chk(name, lat, NIB);
    @(posedge clk);
    #1;
    chk("back_to_idle", {30'b0, in_ready, out_valid}, 32'h2);
  endtask

  initial begin
    logic [NIB-1:0] cins;
    int             w, lat;

    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_cin    = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", {15'b0, cout, result}, 0);
    chk("rst_add", {23'b0, add_a, add_b, add_cin}, 0);
    rst = 1'b0;

    simple_op(16'h1234, 16'h0FFF, 1'b0, "lat_1234", cins);
    simple_op(16'hFFFF, 16'h0001, 1'b0, "lat_ffff_1", cins);
    chk("carry_chain", cins, 4'b1110);
    simple_op(16'hFFFF, 16'hFFFF, 1'b1, "lat_max", cins);
    chk("carry_chain_max", cins, 4'b1111);
    simple_op(16'h0000, 16'h0000, 1'b0, "lat_zero", cins);
    chk("no_stale_carry", cins, 4'b0000);

    // Backpressure: result held in DONE, an in_valid pulse there is ignored.
    out_ready = 1'b0;
    issue(16'h1357, 16'h2468, 1'b1, 1'b0, w);
    wait_done(lat, cins);
    chk("lat_bp", lat, NIB);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold", {14'b0, out_valid, in_ready, cout, result}, {14'b0, 2'b10, 17'h037C0});
      if (k == 1) begin
        op_a     = 16'h1111;
        op_b     = 16'h1111;
        op_cin   = 1'b0;
        in_valid = 1'b1;
      end
      if (k == 2) in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", {30'b0, in_ready, out_valid}, 32'h2);
    simple_op(16'h1111, 16'h1111, 1'b0, "lat_1111", cins);

    // Asynchronous reset during the second RUN cycle.
    issue(16'h8888, 16'h8888, 1'b0, 1'b0, w);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_ready_valid", {30'b0, in_ready, out_valid}, 32'h2);
    chk("arst_result", {15'b0, cout, result}, 0);
    chk("arst_add_cin", add_cin, 0);
    sb.delete();
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    simple_op(16'h0001, 16'h0002, 1'b0, "lat_after_rst", cins);

    // Back-to-back with in_valid and out_ready held high.
    for (int j = 0; j < 3; j++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1, w);
      if (j > 0) chk("b2b_gap", w, NIB + 1);
    end
    in_valid = 1'b0;
    wait_done(lat, cins);
    chk("lat_b2b", lat, NIB);
    @(posedge clk);
    #1;

    // Randomized operations with random idle gaps.
    repeat (20) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      simple_op(W'($urandom), W'($urandom), 1'($urandom), "lat_rand", cins);
    end

    for (int t = 0; t < 50 && sb.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
